// File: rtl/sync_bin_count_up_mod_pkg.sv
// rtl/sync_bin_count_up_mod_pkg.sv - shared counter package: width limit, command priority, next-count helper
package count_pkg;

  localparam int MAX_NBITS = 32;

  // Per-edge command, listed in decreasing priority
  typedef enum logic [1:0] {
    CMD_CLR  = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_CNT  = 2'd2,
    CMD_HOLD = 2'd3
  } cmd_e;

  // Returns {wrap, next}; terminal test is >= so out-of-range values fold back to 0
  function automatic logic [MAX_NBITS:0] next_count(
    input logic [MAX_NBITS-1:0] cur,
    input logic [MAX_NBITS-1:0] lim,
    input logic                 ena
  );
    if (!ena) begin
      return {1'b0, cur};
    end
    if (cur >= lim) begin
      return {1'b1, {MAX_NBITS{1'b0}}};
    end
    return {1'b0, cur + MAX_NBITS'(1)};
  endfunction

endpackage

// File: rtl/sync_bin_count_up_mod_if.sv
// rtl/sync_bin_count_up_mod_if.sv - control and status bundle of the up counter
interface sync_bin_count_up_mod_if #(
  parameter int Nbits = 4
);

  logic             ena;
  logic             clr;
  logic             load;
  logic [Nbits-1:0] load_val;
  logic [Nbits-1:0] max_val;
  logic [Nbits-1:0] cmp_val;
  logic             ovf_clr;
  logic [Nbits-1:0] counter;
  logic             carry_out;
  logic             wrap;
  logic             cmp_match;
  logic             ovf_sticky;

  modport master (
    output ena, clr, load, load_val, max_val, cmp_val, ovf_clr,
    input  counter, carry_out, wrap, cmp_match, ovf_sticky
  );

  modport slave (
    input  ena, clr, load, load_val, max_val, cmp_val, ovf_clr,
    output counter, carry_out, wrap, cmp_match, ovf_sticky
  );

endinterface

// File: rtl/sync_bin_count_up_mod_cell.sv
// rtl/sync_bin_count_up_mod_cell.sv - one counter bit: async reset, sync load, toggle enable
module count_up_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  input  logic ld,
  input  logic d,
  input  logic chain_in,
  output logic q,
  output logic chain_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_BIT;
    end else if (ld) begin
      q <= d;
    end else if (tgl) begin
      q <= ~q;
    end
  end

  // Ones-prefix: high when this bit and every lower bit are 1
  assign chain_out = chain_in & q;

endmodule

// File: rtl/sync_bin_count_up_mod.sv
// rtl/sync_bin_count_up_mod.sv - programmable-terminal binary up counter with carry, wrap, compare and overflow flags
module sync_bin_count_up_mod
  import count_pkg::*;
#(
  parameter int               Nbits   = 4,
  parameter logic [Nbits-1:0] RST_VAL = '0
) (
  input logic                   clk,
  input logic                   rst,
  sync_bin_count_up_mod_if.slave bus
);

  cmd_e                   cmd;
  logic [MAX_NBITS:0]     nc;
  logic                   at_term;
  logic                   do_wrap;
  logic                   inc;
  logic                   ld;
  logic [Nbits-1:0]       ld_val;
  logic [Nbits-1:0]       cnt;
  logic [Nbits:0]         pre;
  logic [MAX_NBITS-1:0]   nxt_wide;
  logic                   hit;
  logic                   unused_all_ones;
  logic                   wrap_q;
  logic                   cmp_q;
  logic                   ovf_q;

  always_comb begin
    cmd = CMD_HOLD;
    if (bus.clr) begin
      cmd = CMD_CLR;
    end else if (bus.load) begin
      cmd = CMD_LOAD;
    end else if (bus.ena) begin
      cmd = CMD_CNT;
    end
  end

  assign nc      = next_count(MAX_NBITS'(cnt), MAX_NBITS'(bus.max_val), bus.ena);
  assign at_term = nc[MAX_NBITS];
  assign do_wrap = (cmd == CMD_CNT) && at_term;
  assign inc     = (cmd == CMD_CNT) && !at_term;
  assign ld      = (cmd == CMD_CLR) || (cmd == CMD_LOAD) || do_wrap;

  always_comb begin
    ld_val = '0;
    if (cmd == CMD_CLR) begin
      ld_val = RST_VAL;
    end else if (cmd == CMD_LOAD) begin
      ld_val = bus.load_val;
    end
  end

  // Ripple-toggle increment: bit i flips when all lower bits are 1
  assign pre[0] = 1'b1;

  for (genvar i = 0; i < Nbits; i++) begin : g_cell
    count_up_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .tgl       (inc & pre[i]),
      .ld        (ld),
      .d         (ld_val[i]),
      .chain_in  (pre[i]),
      .q         (cnt[i]),
      .chain_out (pre[i+1])
    );
  end

  // All-ones always satisfies the terminal test, so the top carry never propagates
  assign unused_all_ones = pre[Nbits];

  // Value written on this edge, used only for compare-match detection
  always_comb begin
    nxt_wide = MAX_NBITS'(cnt);
    case (cmd)
      CMD_CLR:  nxt_wide = MAX_NBITS'(RST_VAL);
      CMD_LOAD: nxt_wide = MAX_NBITS'(bus.load_val);
      CMD_CNT:  nxt_wide = nc[MAX_NBITS-1:0];
      default:  nxt_wide = MAX_NBITS'(cnt);
    endcase
  end

  assign hit = (nxt_wide == MAX_NBITS'(bus.cmp_val)) && (nxt_wide != MAX_NBITS'(cnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
      cmp_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= do_wrap;
      cmp_q  <= hit;
      ovf_q  <= do_wrap || (ovf_q && !bus.ovf_clr);
    end
  end

  assign bus.counter    = cnt;
  assign bus.carry_out  = at_term && !bus.clr && !bus.load;
  assign bus.wrap       = wrap_q;
  assign bus.cmp_match  = cmp_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_sync_bin_count_up_mod.sv
// tb/tb_sync_bin_count_up_mod.sv - self-checking bench for sync_bin_count_up_mod
module tb_sync_bin_count_up_mod;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmps = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sync_bin_count_up_mod_if #(.Nbits(N)) bus ();
  sync_bin_count_up_mod_if #(.Nbits(N)) lo ();
  sync_bin_count_up_mod_if #(.Nbits(N)) hi ();

  sync_bin_count_up_mod #(.Nbits(N), .RST_VAL(4'd0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  sync_bin_count_up_mod #(.Nbits(N), .RST_VAL(4'd0)) u_lo  (.clk(clk), .rst(rst), .bus(lo));
  sync_bin_count_up_mod #(.Nbits(N), .RST_VAL(4'd0)) u_hi  (.clk(clk), .rst(rst), .bus(hi));

  assign hi.ena      = lo.carry_out;
  assign hi.clr      = 1'b0;
  assign hi.load     = 1'b0;
  assign hi.load_val = 4'd0;
  assign hi.max_val  = 4'd9;
  assign hi.cmp_val  = 4'd0;
  assign hi.ovf_clr  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented rules
  int m_cnt = 0, m_wrap = 0, m_cmp = 0, m_ovf = 0, c_n = 0;

  always @(posedge clk or posedge rst) begin
    int old_v, new_v, w;
    if (rst) begin
      m_cnt = 0; m_wrap = 0; m_cmp = 0; m_ovf = 0; c_n = 0;
    end else begin
      old_v = m_cnt;
      w = 0;
      if (bus.clr) new_v = 0;
      else if (bus.load) new_v = int'(bus.load_val);
      else if (bus.ena) begin
        if (old_v >= int'(bus.max_val)) begin
          new_v = 0;
          w = 1;
        end else new_v = old_v + 1;
      end else new_v = old_v;
      m_cnt  = new_v;
      m_wrap = w;
      m_cmp  = (new_v == int'(bus.cmp_val) && new_v != old_v) ? 1 : 0;
      m_ovf  = (w == 1 || (m_ovf == 1 && !bus.ovf_clr)) ? 1 : 0;
      if (lo.ena) c_n++;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("counter", bus.counter, m_cnt);
    chk("wrap", bus.wrap, m_wrap);
    chk("cmp_match", bus.cmp_match, m_cmp);
    chk("ovf_sticky", bus.ovf_sticky, m_ovf);
    chk("casc_lo", lo.counter, c_n % 10);
    chk("casc_hi", hi.counter, (c_n / 10) % 10);
  end

  always @(negedge clk) begin
    chk("carry_out", bus.carry_out,
        (bus.ena && !bus.clr && !bus.load && m_cnt >= int'(bus.max_val)) ? 1 : 0);
    chk("casc_carry", lo.carry_out, (lo.ena && (c_n % 10) == 9) ? 1 : 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    bus.ena = 0; bus.clr = 0; bus.load = 0; bus.load_val = 0;
    bus.max_val = 9; bus.cmp_val = 15; bus.ovf_clr = 0;
    lo.ena = 0; lo.clr = 0; lo.load = 0; lo.load_val = 0;
    lo.max_val = 9; lo.cmp_val = 0; lo.ovf_clr = 0;
    rst = 1;
    tick(2);
    rst = 0;
    chk("reset_counter", bus.counter, 0);
    chk("reset_flags", {bus.wrap, bus.cmp_match, bus.ovf_sticky}, 0);

    // Async reset mid-cycle at count 9
    bus.ena = 1;
    tick(9);
    chk("pre_rst_cnt", bus.counter, 9);
    #2 rst = 1;
    #2;
    chk("async_rst_cnt", bus.counter, 0);
    chk("async_rst_flags", {bus.wrap, bus.cmp_match, bus.ovf_sticky}, 0);
    #1 rst = 0;
    @(posedge clk);
    #2;
    chk("first_after_rst", bus.counter, 1);

    // Modulo-10 wrap
    bus.clr = 1;
    tick();
    bus.clr = 0;
    for (int i = 0; i < 12; i++) begin
      chk("mod_carry", bus.carry_out, (i % 10 == 9) ? 1 : 0);
      tick();
      chk("mod_cnt", bus.counter, (i + 1) % 10);
      if (i == 9) chk("mod_wrap", bus.wrap, 1);
    end
    chk("mod_ovf", bus.ovf_sticky, 1);

    // Out-of-range load folds back to 0; clr beats load
    bus.max_val = 5; bus.load = 1; bus.load_val = 12;
    tick();
    chk("load_oor", bus.counter, 12);
    bus.load = 0;
    tick();
    chk("oor_wrap_cnt", bus.counter, 0);
    chk("oor_wrap", bus.wrap, 1);
    tick();
    bus.load = 1; bus.clr = 1; bus.load_val = 7;
    tick();
    chk("clr_beats_load", bus.counter, 0);
    bus.load = 0; bus.clr = 0;

    // max_val = 0: every enabled edge wraps
    bus.max_val = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("max0_cnt", bus.counter, 0);
      chk("max0_wrap", bus.wrap, 1);
    end

    // Free-running at max_val = 15
    bus.max_val = 15; bus.load = 1; bus.load_val = 13;
    tick();
    bus.load = 0;
    tick();
    chk("free_14", {bus.counter, bus.wrap}, {4'd14, 1'b0});
    tick();
    chk("free_15", {bus.counter, bus.wrap}, {4'd15, 1'b0});
    tick();
    chk("free_0", {bus.counter, bus.wrap}, {4'd0, 1'b1});

    // Compare-match pulses
    bus.ena = 0; bus.clr = 1;
    tick();
    bus.clr = 0; bus.max_val = 9; bus.cmp_val = 3; bus.ovf_clr = 1;
    tick();
    bus.ovf_clr = 0;
    chk("ovf_cleared", bus.ovf_sticky, 0);
    bus.ena = 1;
    tick(2);
    chk("cmp_none_2", bus.cmp_match, 0);
    tick();
    chk("cmp_at_3", {bus.counter, bus.cmp_match}, {4'd3, 1'b1});
    bus.ena = 0;
    tick();
    chk("cmp_hold_a", bus.cmp_match, 0);
    tick();
    chk("cmp_hold_b", bus.cmp_match, 0);

    // ovf_clr on the wrap edge loses to the set
    bus.ena = 1;
    tick(6);
    chk("at_9", bus.counter, 9);
    bus.ovf_clr = 1;
    tick();
    chk("ovf_set_wins", {bus.wrap, bus.ovf_sticky}, 2'b11);
    tick();
    chk("ovf_clr_later", {bus.counter, bus.ovf_sticky}, {4'd1, 1'b0});
    bus.ovf_clr = 0; bus.ena = 0;

    // Load into the compare value fires once, reload of same value does not
    bus.load = 1; bus.load_val = 3;
    tick();
    chk("cmp_load", bus.cmp_match, 1);
    tick();
    chk("cmp_reload", bus.cmp_match, 0);
    bus.load = 0;

    // Two-stage decade cascade
    lo.ena = 1;
    tick(100);
    lo.ena = 0;
    chk("casc100", {hi.counter, lo.counter}, 8'h00);
    chk("casc100_wrap", hi.wrap, 1);
    lo.ena = 1;
    tick(57);
    lo.ena = 0;
    chk("casc57", {hi.counter, lo.counter}, 8'h57);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule

// File: doc/sync_bin_count_up_mod.md
Name: sync_bin_count_up_mod

Overview:
- Parameterized synchronous binary up counter with a programmable terminal value and synchronous clear and load.
- Provides a combinational carry-out for cascading, plus a registered wrap pulse, a sticky overflow flag and a compare-match strobe.
- Serves as the up-counting companion to the existing down counter, for timers, address generators and multi-stage prescalers.

Parameters:
- Nbits, 4, width of the count and of all value ports (2..32).
- RST_VAL, 0, value loaded into counter on rst and on clr.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  count enable / carry-in from the previous stage.
- clr  in  1  synchronous clear to RST_VAL.
- load  in  1  synchronous parallel load.
- load_val  in  Nbits  value taken on load.
- max_val  in  Nbits  terminal count; counter runs 0..max_val.
- cmp_val  in  Nbits  compare value.
- ovf_clr  in  1  clears ovf_sticky.
- counter  out  Nbits  registered count.
- carry_out  out  1  combinational: ena & (counter >= max_val) & ~clr & ~load.
- wrap  out  1  registered, one-cycle pulse after a wrap to 0.
- cmp_match  out  1  registered, one-cycle pulse when counter becomes equal to cmp_val.
- ovf_sticky  out  1  set by any wrap, held until ovf_clr.

Behaviour:
- Reset: on rst=1, at any time and independent of clk:
  - counter = RST_VAL
  - wrap = 0, cmp_match = 0, ovf_sticky = 0
  - rst deasserted mid-count: counting resumes from RST_VAL on the first enabled edge.
- Priority per edge: clr > load > ena > hold.
  - clr: counter <= RST_VAL; no wrap.
  - load: counter <= load_val; no wrap.
  - ena=1:
    - if counter >= max_val: counter <= 0, and wrap is 1 in the following cycle.
    - else: counter <= counter + 1.
  - ena=0: hold; wrap <= 0.
- Terminal compare uses >=, so an out-of-range value (after load, or after max_val is lowered) returns to 0 on the next enabled edge.
- max_val=0: counter stays 0, and every enabled edge is a wrap.
- max_val = 2^Nbits-1: free-running binary counter; the +1 at the top never overflows arithmetically because the wrap branch is taken first.
- Arithmetic is unsigned Nbits. The increment is computed Nbits+1 wide and truncated; only the wrap path produces 0.
- carry_out:
  - Same cycle as the wrapping edge; zero latency, so stages can be cascaded with next.ena = this.carry_out.
  - Forced 0 while clr or load is asserted.
- wrap: 1 for exactly one cycle per wrap; back-to-back wraps (max_val=0, ena held high) give wrap held at 1.
- cmp_match:
  - Set for one cycle when the value written into counter on this edge equals cmp_val and differs from the previous value.
  - A hold or a reload of the same value does not retrigger it.
  - Also fires after load or clr if the new value equals cmp_val and differs from the old one.
- ovf_sticky:
  - Set on the same edge that registers wrap.
  - ovf_clr clears it.
  - Simultaneous set and ovf_clr: set wins.
- Latency: counter updates one clock after the controlling inputs are sampled. wrap, cmp_match and ovf_sticky are registered alongside counter, so they are valid in the same cycle as the new count.

Decomposition:
- Shared package count_pkg:
  - localparam MAX_NBITS = 32
  - priority-encoding constants CMD_CLR, CMD_LOAD, CMD_CNT, CMD_HOLD
  - a function next_count(cur, max, ena) returning {wrap, next}, reused by the down-counter refactor.
- One natural sub-module, count_up_cell:
  - One bit with async reset, toggle-enable input and synchronous load input; outputs its q and its chain term.
  - The top module generates Nbits cells, plus the terminal compare and flag logic.

Test Plan:
- Reset: rst pulsed asynchronously mid-cycle with counter=9 -> counter=0, flags=0 immediately; first enabled edge after release -> counter=1.
- Modulo wrap: Nbits=4, max_val=9, ena=1 for 12 edges -> counter 1..9, 0, 1, 2. carry_out=1 only during the cycle counter=9. wrap=1 in the cycle counter=0. ovf_sticky=1 from then on.
- Load out of range: max_val=5, load with load_val=12 -> counter=12; next enabled edge -> counter=0 and wrap=1. Then load and clr together -> counter=RST_VAL (clr wins).
- max_val=0 and free-run: max_val=0 with ena high for 3 edges -> counter=0 and wrap=1 on all three cycles. max_val=15 -> counter 14, 15, 0 with wrap only after 15.
- Cascade: two instances, second ena = first carry_out, both max_val=9, 100 enables -> {hi,lo} = {0,0} with hi wrap=1. After 57 enables -> {5,7}.
- Flags: cmp_val=3 -> a single cmp_match pulse as counter reaches 3, none while holding at 3 with ena=0. ovf_clr asserted on a wrap edge -> ovf_sticky stays 1. ovf_clr on a later edge -> 0.
